// File: rtl/decoded_bit_packer.sv
// Packs the top code_length bits of each decoded word MSB-first into AXI-Stream bytes.
// Defining PACKER_STATS_EN adds the frame_count / byte_count output counters.
module decoded_bit_packer #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 s_axis_aresetn,
  input  logic [LEN_WIDTH-1:0] code_length,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
`ifdef PACKER_STATS_EN
  output logic [15:0]          frame_count,
  output logic [31:0]          byte_count,
`endif
  output logic [3:0]           m_axis_tuser
);

  localparam int ACC_W = IN_WIDTH + OUT_WIDTH - 1;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam int LW    = $clog2(IN_WIDTH + 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [LW-1:0]    len_q;
  logic             frame_start;
  logic             flush_pending;
  logic             had_bits;

  logic             slot_free;
  logic             out_hs;
  logic             in_hs;
  logic [LW-1:0]    len_cur;
  logic [IN_WIDTH-1:0] keep_mask;
  logic [ACC_W-1:0] word_al;
  logic [ACC_W-1:0] acc_mid;
  logic [CNT_W-1:0] cnt_mid;
  logic             last_seen;
  logic             bits_seen;
  logic             load_full;
  logic             load_flush;

  assign slot_free     = !m_axis_tvalid || m_axis_tready;
  assign out_hs        = m_axis_tvalid && m_axis_tready;
  assign s_axis_tready = (cnt < CNT_W'(OUT_WIDTH)) && !flush_pending &&
                         !(m_axis_tvalid && !m_axis_tready);
  assign in_hs         = s_axis_tvalid && s_axis_tready;

  always_comb begin
    len_cur = len_q;
    if (frame_start) begin
      if (code_length > LEN_WIDTH'(IN_WIDTH)) len_cur = LW'(IN_WIDTH);
      else                                    len_cur = code_length[LW-1:0];
    end
    keep_mask = ~({IN_WIDTH{1'b1}} >> len_cur);
    // New bits land directly below the cnt bits already held; lower bits stay zero.
    word_al   = {s_axis_tdata & keep_mask, {(OUT_WIDTH-1){1'b0}}};
    acc_mid   = acc;
    cnt_mid   = cnt;
    if (in_hs) begin
      acc_mid = acc | (word_al >> cnt);
      cnt_mid = cnt + CNT_W'(len_cur);
    end
    last_seen  = flush_pending || (in_hs && s_axis_tlast);
    bits_seen  = had_bits || (in_hs && (len_cur != '0));
    load_full  = slot_free && (cnt_mid >= CNT_W'(OUT_WIDTH));
    // A tail byte is only emitted once no byte carrying tlast is still outstanding.
    load_flush = !load_full && slot_free && flush_pending &&
                 !(out_hs && m_axis_tlast) && (cnt < CNT_W'(OUT_WIDTH)) &&
                 ((cnt != '0) || !had_bits);
  end

  always_ff @(posedge clk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      acc           <= '0;
      cnt           <= '0;
      len_q         <= '0;
      frame_start   <= 1'b1;
      flush_pending <= 1'b0;
      had_bits      <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else begin
      if (in_hs) begin
        frame_start <= s_axis_tlast;
        if (frame_start) len_q <= len_cur;
      end

      if (in_hs && s_axis_tlast)        flush_pending <= 1'b1;
      else if (out_hs && m_axis_tlast)  flush_pending <= 1'b0;

      had_bits <= (out_hs && m_axis_tlast) ? 1'b0 : bits_seen;

      if (load_full) begin
        m_axis_tdata  <= acc_mid[ACC_W-1 -: OUT_WIDTH];
        m_axis_tuser  <= 4'(OUT_WIDTH);
        m_axis_tlast  <= last_seen && (cnt_mid == CNT_W'(OUT_WIDTH));
        m_axis_tvalid <= 1'b1;
        acc           <= acc_mid << OUT_WIDTH;
        cnt           <= cnt_mid - CNT_W'(OUT_WIDTH);
      end else if (load_flush) begin
        m_axis_tdata  <= acc[ACC_W-1 -: OUT_WIDTH];
        m_axis_tuser  <= 4'(cnt);
        m_axis_tlast  <= 1'b1;
        m_axis_tvalid <= 1'b1;
        acc           <= '0;
        cnt           <= '0;
      end else begin
        acc <= acc_mid;
        cnt <= cnt_mid;
        if (out_hs) m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef PACKER_STATS_EN
  always_ff @(posedge clk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      frame_count <= '0;
      byte_count  <= '0;
    end else if (out_hs) begin
      byte_count <= byte_count + 32'd1;
      if (m_axis_tlast) frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decoded_bit_packer.sv
// Scoreboard bench for decoded_bit_packer: directed frames, expectations queued, monitor compares.
module tb_decoded_bit_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  code_length = '0;
  logic [15:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic [3:0]  m_tuser;
`ifdef PACKER_STATS_EN
  logic [15:0] frame_count;
  logic [31:0] byte_count;
`endif

  decoded_bit_packer dut (
    .clk            (clk),
    .s_axis_aresetn (rst_n),
    .code_length    (code_length),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .s_axis_tlast   (s_tlast),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tlast   (m_tlast),
`ifdef PACKER_STATS_EN
    .frame_count    (frame_count),
    .byte_count     (byte_count),
`endif
    .m_axis_tuser   (m_tuser)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] u;
    logic       l;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   ready_mode = 0;  // 0 high, 1 low, 2 toggling

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic [3:0] u, input logic l);
    exp_t e;
    e.d = d; e.u = u; e.l = l;
    q.push_back(e);
  endtask

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: m_tready = 1'b1;
      1: m_tready = 1'b0;
      default: m_tready = ~m_tready;
    endcase
  end

  // Monitor: pops on each output handshake, checks stall stability.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d;
  logic [3:0] prev_u;
  logic       prev_l;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, m_tvalid}, 32'd1);
        chk("stall_stable", {19'd0, m_tdata, m_tuser, m_tlast}, {19'd0, prev_d, prev_u, prev_l});
      end
      if (m_tvalid && m_tready) begin
        if (q.size() == 0) begin
          chk("unexpected_byte", {19'd0, m_tdata, m_tuser, m_tlast}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("byte", {19'd0, m_tdata, m_tuser, m_tlast}, {19'd0, e.d, e.u, e.l});
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata; prev_u = m_tuser; prev_l = m_tlast;
    end
  end

  task automatic send(input logic [15:0] d, input logic [7:0] len, input logic last);
    bit hs;
    int n;
    code_length = len; s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
    hs = 0; n = 0;
    while (!hs && n < 300) begin
      @(negedge clk);
      hs = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    checks++;
    if (!hs) begin
      failures++;
      $display("FAIL send_timeout actual=no_handshake required=handshake word=0x%0h", d);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #23;
    chk("reset_tvalid", {31'd0, m_tvalid}, 0);
    chk("reset_outputs", {19'd0, m_tdata, m_tuser, m_tlast}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1) L=10 two words
    expect_byte(8'hAB, 4'd8, 1'b0);
    expect_byte(8'hFF, 4'd8, 1'b0);
    expect_byte(8'hF0, 4'd4, 1'b1);
    send(16'hABC0, 8'd10, 1'b0);
    send(16'hFFC0, 8'd10, 1'b1);
    drain("t1_drain");

    // 2) L=8 single word, no extra flush byte
    expect_byte(8'h5A, 4'd8, 1'b1);
    send(16'h5A00, 8'd8, 1'b1);
    drain("t2_drain");

    // 3) L=5 with a long output stall, then toggling ready
    expect_byte(8'hF8, 4'd8, 1'b0);
    expect_byte(8'h3E, 4'd8, 1'b0);
    expect_byte(8'h00, 4'd4, 1'b1);
    ready_mode = 1;
    fork
      begin
        send(16'hF800, 8'd5, 1'b0);
        send(16'h0000, 8'd5, 1'b0);
        send(16'hF800, 8'd5, 1'b0);
        send(16'h0000, 8'd5, 1'b1);
      end
      begin
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("t3_stall_tready", {31'd0, s_tready}, 0);
        chk("t3_stall_byte", {23'd0, m_tvalid, m_tdata}, {23'd0, 1'b1, 8'hF8});
        @(posedge clk); #1;
        ready_mode = 2;
      end
    join
    drain("t3_drain");
    ready_mode = 0;
    @(posedge clk); #1;

    // 4) empty frame marker
    expect_byte(8'h00, 4'd0, 1'b1);
    send(16'hFFFF, 8'd0, 1'b1);
    drain("t4_drain");

    // 5) code_length change mid-frame ignored; next frame uses 5; >16 would clamp
    expect_byte(8'hAB, 4'd8, 1'b0);
    expect_byte(8'hFF, 4'd8, 1'b0);
    expect_byte(8'hF0, 4'd4, 1'b1);
    expect_byte(8'hF8, 4'd5, 1'b1);
    send(16'hABC0, 8'd10, 1'b0);
    send(16'hFFC0, 8'd5, 1'b1);
    send(16'hFFFF, 8'd5, 1'b1);
    drain("t5_drain");

    // 6) reset mid-frame discards 2 held bits
    expect_byte(8'hAB, 4'd8, 1'b0);
    send(16'hABC0, 8'd10, 1'b0);
    drain("t6a_drain");
    rst_n = 1'b0;
    #2;
    chk("t6_reset_tvalid", {31'd0, m_tvalid}, 0);
    chk("t6_reset_outputs", {19'd0, m_tdata, m_tuser, m_tlast}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_byte(8'h5A, 4'd8, 1'b1);
    send(16'h5A00, 8'd8, 1'b1);
    drain("t6b_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
